// File: rtl/sound_pkg.sv
// sound_pkg: shared constants and helpers for the APU mixer slice.
//   - Channel/level/sample widths.
//   - NR50 / NR51 bit-field positions.
//   - sound_scale(): master-volume multiply (sum * (vol+1)).
package sound_pkg;

  localparam int SOUND_LEVEL_W  = 4;
  localparam int SOUND_SAMPLE_W = 9;
  localparam int SOUND_NUM_CH   = 4;
  localparam int SOUND_SUM_W    = 6;  // 4 * 15 = 60 fits in 6 bits

  // NR51: upper nibble routes ch4..ch1 to left, lower nibble to right.
  localparam int NR51_LEFT_LSB  = 4;
  localparam int NR51_RIGHT_LSB = 0;

  // NR50: 3-bit volumes; bits 7 and 3 (Vin) are not used here.
  localparam int NR50_VOL_W     = 3;
  localparam int NR50_LEFT_LSB  = 4;
  localparam int NR50_RIGHT_LSB = 0;

  typedef logic [SOUND_NUM_CH-1:0][SOUND_LEVEL_W-1:0] sound_levels_t;

  // Max 60 * 8 = 480, so the 9-bit result never overflows.
  function automatic logic [SOUND_SAMPLE_W-1:0] sound_scale(
    input logic [SOUND_SUM_W-1:0] sum,
    input logic [NR50_VOL_W-1:0]  vol
  );
    logic [SOUND_SAMPLE_W-1:0] s;
    logic [SOUND_SAMPLE_W-1:0] v;
    s = {{(SOUND_SAMPLE_W-SOUND_SUM_W){1'b0}}, sum};
    v = {{(SOUND_SAMPLE_W-NR50_VOL_W){1'b0}}, vol} + 9'd1;
    return s * v;
  endfunction

endpackage

// File: rtl/sound_dsm.sv
// sound_dsm: first-order delta-sigma modulator, one per output side.
//   clk    - clock
//   rst    - asynchronous reset, active low
//   clr    - synchronous clear (mixer disabled)
//   sample - held 9-bit PCM sample
//   pdm    - 1-bit stream, ones density = sample / 512
module sound_dsm
  import sound_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [SOUND_SAMPLE_W-1:0] sample,
  output logic                      pdm
);

  logic [SOUND_SAMPLE_W:0] acc;

  // Bit 9 is the carry out of the 9-bit accumulation; it is dropped
  // from the feedback so the residue stays in [0, 511].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      pdm <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      pdm <= 1'b0;
    end else begin
      acc <= {1'b0, acc[SOUND_SAMPLE_W-1:0]} + {1'b0, sample};
      pdm <= acc[SOUND_SAMPLE_W];
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// sound_mixer: final APU stage. Gates the four channel levels through
// NR51 routing, sums per side, scales by NR50 master volume and emits
// unsigned 9-bit L/R samples once every SAMPLE_DIV+1 cycles.
//
// Optional macro SOUND_MIXER_DSM_EN adds a delta-sigma modulator per
// side on pdm_l / pdm_r; without it those pins are tied low.
//
// Ports:
//   clk          - clock
//   rst          - asynchronous reset, active low
//   ch_level     - [3:0]=ch1 .. [15:12]=ch4 levels
//   ch_enable    - bit i = channel i+1 enabled
//   nr50         - master volume ([6:4] left, [2:0] right)
//   nr51         - routing ([7:4] left, [3:0] right; ch4..ch1)
//   master_en    - NR52 bit 7; low clears everything
//   left, right  - held PCM samples, 0..480
//   sample_valid - one-cycle strobe when left/right update
//   pdm_l, pdm_r - delta-sigma bitstreams
//
// Pipeline (vld_pipe bit n set after edge En):
//   E0 divider wraps, E1 tick, E2 gated capture, E3 sums, E4 output.
module sound_mixer
  import sound_pkg::*;
#(
  parameter int SAMPLE_DIV = 95
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [SOUND_NUM_CH*SOUND_LEVEL_W-1:0]   ch_level,
  input  logic [SOUND_NUM_CH-1:0]                 ch_enable,
  input  logic [7:0]                              nr50,
  input  logic [7:0]                              nr51,
  input  logic                                    master_en,
  output logic [SOUND_SAMPLE_W-1:0]               left,
  output logic [SOUND_SAMPLE_W-1:0]               right,
  output logic                                    sample_valid,
  output logic                                    pdm_l,
  output logic                                    pdm_r
);

  localparam int STAGES = 4;

  logic [6:0]              div_cnt;
  logic                    wrap;
  logic                    tick;
  logic [STAGES:0]         vld_pipe;

  sound_levels_t           lvl;
  sound_levels_t           gl, gr;
  sound_levels_t           gl_q, gr_q;
  logic [SOUND_SUM_W-1:0]  sum_l, sum_r;
  logic [SOUND_SUM_W-1:0]  sum_l_q, sum_r_q;

  assign lvl  = ch_level;
  assign wrap = (div_cnt == 7'(SAMPLE_DIV));
  assign tick = vld_pipe[1];

  // Per-channel routing gates, evaluated against live NR51 so a write
  // landing before the capture edge affects the current sample.
  for (genvar i = 0; i < SOUND_NUM_CH; i++) begin : g_gate
    assign gl[i] = (ch_enable[i] && nr51[NR51_LEFT_LSB+i])  ? lvl[i] : '0;
    assign gr[i] = (ch_enable[i] && nr51[NR51_RIGHT_LSB+i]) ? lvl[i] : '0;
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < SOUND_NUM_CH; i++) begin
      sum_l = sum_l + SOUND_SUM_W'(gl_q[i]);
      sum_r = sum_r + SOUND_SUM_W'(gr_q[i]);
    end
  end

  // master_en low behaves like a synchronous clear of the whole datapath,
  // which also drops any sample still travelling through vld_pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      vld_pipe <= '0;
      gl_q     <= '0;
      gr_q     <= '0;
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      left     <= '0;
      right    <= '0;
    end else if (!master_en) begin
      div_cnt  <= '0;
      vld_pipe <= '0;
      gl_q     <= '0;
      gr_q     <= '0;
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      left     <= '0;
      right    <= '0;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + 7'd1;
      vld_pipe <= {vld_pipe[STAGES-1:0], wrap};
      if (tick) begin
        gl_q <= gl;
        gr_q <= gr;
      end
      if (vld_pipe[2]) begin
        sum_l_q <= sum_l;
        sum_r_q <= sum_r;
      end
      if (vld_pipe[3]) begin
        left  <= sound_scale(sum_l_q, nr50[NR50_LEFT_LSB  +: NR50_VOL_W]);
        right <= sound_scale(sum_r_q, nr50[NR50_RIGHT_LSB +: NR50_VOL_W]);
      end
    end
  end

  assign sample_valid = vld_pipe[STAGES];

`ifdef SOUND_MIXER_DSM_EN
  sound_dsm u_dsm_l (
    .clk    (clk),
    .rst    (rst),
    .clr    (!master_en),
    .sample (left),
    .pdm    (pdm_l)
  );

  sound_dsm u_dsm_r (
    .clk    (clk),
    .rst    (rst),
    .clr    (!master_en),
    .sample (right),
    .pdm    (pdm_r)
  );
`else
  assign pdm_l = 1'b0;
  assign pdm_r = 1'b0;
`endif

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer (default SAMPLE_DIV = 95).
module tb_sound_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ch_level;
  logic [3:0]  ch_enable;
  logic [7:0]  nr50, nr51;
  logic        master_en;
  logic [8:0]  left, right;
  logic        sample_valid, pdm_l, pdm_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_mixer #(.SAMPLE_DIV(95)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_level     (ch_level),
    .ch_enable    (ch_enable),
    .nr50         (nr50),
    .nr51         (nr51),
    .master_en    (master_en),
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid),
    .pdm_l        (pdm_l),
    .pdm_r        (pdm_r)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Negedges until sample_valid is seen (bounded; 400 means timeout).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 400);
  endtask

  // Skip a possibly mixed in-flight sample, then return the period of
  // the next fully settled one.
  task automatic settle(output int n);
    int d;
    wait_valid(d);
    wait_valid(n);
  endtask

  task automatic count_ones(input int cycles, output int ones_l, output int ones_r);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ones_l += int'(pdm_l);
      ones_r += int'(pdm_r);
    end
  endtask

  initial begin
    int n, pulses, ol, or_;
    int exp_half;
`ifdef SOUND_MIXER_DSM_EN
    exp_half = 256;
`else
    exp_half = 0;
`endif

    // Reset held with every input active
    rst       = 1'b0;
    ch_level  = 16'hFFFF;
    ch_enable = 4'hF;
    nr51      = 8'hFF;
    nr50      = 8'h77;
    master_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_left",  left, 0);
    chk("rst_right", right, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_pdm",   {pdm_l, pdm_r}, 0);

    // First pulse: wrap at edge 96 after release, output 4 edges later
    rst = 1'b1;
    wait_valid(n);
    chk("first_latency", n, 100);
    chk("first_left",  left, 480);
    chk("first_right", right, 480);
    @(negedge clk);
    chk("valid_one_cycle", sample_valid, 0);

    // Routing
    ch_level = 16'h000F; ch_enable = 4'b0001; nr51 = 8'h10; nr50 = 8'h77;
    settle(n);
    chk("period", n, 96);
    chk("route_l_left",  left, 120);
    chk("route_l_right", right, 0);
    nr51 = 8'h01;
    settle(n);
    chk("route_r_left",  left, 0);
    chk("route_r_right", right, 120);

    // Full scale and channel disable
    ch_level = 16'hFFFF; ch_enable = 4'hF; nr51 = 8'hFF; nr50 = 8'h70;
    settle(n);
    chk("full_left",  left, 480);
    chk("full_right", right, 60);
    ch_enable = 4'b1011;
    settle(n);
    chk("noch3_left",  left, 360);
    chk("noch3_right", right, 45);
    wait_valid(n);
    chk("period2", n, 96);

    // Drop master_en at cycle 50 of a period
    repeat (50) @(negedge clk);
    master_en = 1'b0;
    @(negedge clk);
    chk("gate_left",  left, 0);
    chk("gate_right", right, 0);
    pulses = int'(sample_valid);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid);
    end
    chk("gate_no_pulse", pulses, 0);
    master_en = 1'b1;
    wait_valid(n);
    chk("reenable_latency", n, 100);
    chk("reenable_left",  left, 360);
    chk("reenable_right", right, 45);

    // DSM: left = (15+15+2)*8 = 256, right = 0
    ch_level = 16'h02FF; ch_enable = 4'b0111; nr51 = 8'h70; nr50 = 8'h70;
    settle(n);
    chk("dsm_left",  left, 256);
    chk("dsm_right", right, 0);
    count_ones(512, ol, or_);
    chk("dsm_half_l", ol, exp_half);
    chk("dsm_zero_r", or_, 0);
    nr51 = 8'h00;
    settle(n);
    chk("dsm0_left", left, 0);
    count_ones(512, ol, or_);
    chk("dsm0_l", ol, 0);
    chk("dsm0_r", or_, 0);

    // Reset mid-pipeline: wrap has happened, sample in flight
    ch_level = 16'hFFFF; ch_enable = 4'hF; nr51 = 8'hFF; nr50 = 8'h77;
    settle(n);
    repeat (94) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_left",  left, 0);
    chk("arst_valid", sample_valid, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid);
    end
    chk("arst_no_pulse", pulses, 0);
    rst = 1'b1;
    wait_valid(n);
    chk("arst_latency", n, 100);
    chk("arst_left2", left, 480);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
